// File: rtl/key_offset_lookup.sv
// Per-stage key-offset/key-mask lookup indexed by VLAN ID, placed ahead of the key extractor.
// Emits the PHV with its selected offset/mask words in one aligned beat, 1 PHV per 3 cycles.
module key_offset_lookup #(
  parameter int unsigned STAGE_ID           = 0,
  parameter int unsigned NUM_PER_TYPE       = 8,
  parameter int unsigned PHV_LEN            = 48*NUM_PER_TYPE+32*NUM_PER_TYPE+16*NUM_PER_TYPE+256,
  parameter int unsigned KEY_OFF            = (3+3)*3+20,
  parameter int unsigned KEY_LEN            = 48*2+32*2+16*2+1,
  parameter int unsigned KEY_OFF_ADDR_WIDTH = 4,
  parameter int unsigned C_VLANID_WIDTH     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_valid_in,
  input  logic [C_VLANID_WIDTH-1:0]     vlan_id_in,
  output logic                          ready_out,
  input  logic                          cfg_wr_en,
  input  logic [7:0]                    cfg_wr_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [KEY_OFF-1:0]            cfg_wr_offset,
  input  logic [KEY_LEN-1:0]            cfg_wr_mask,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_valid_out,
  output logic                          key_offset_valid,
  output logic [KEY_OFF-1:0]            key_offset_out,
  output logic [KEY_LEN-1:0]            key_mask_out,
  input  logic                          ready_in
);

  localparam int unsigned Entries  = 1 << KEY_OFF_ADDR_WIDTH;
  localparam int unsigned EntryW   = KEY_OFF + KEY_LEN;
  localparam logic [7:0]  StageSel = STAGE_ID[7:0];

  typedef enum logic [1:0] {StIdle, StLookup, StEmit} state_e;

  state_e                          state_q, state_d;
  logic [EntryW-1:0]               mem [Entries];
  logic [EntryW-1:0]               rd_data_q;
  logic                            rd_hit_q;
  logic [Entries-1:0]              entry_vld_q;
  logic [PHV_LEN-1:0]              phv_q;
  logic [KEY_OFF_ADDR_WIDTH-1:0]   idx;
  logic                            wr_hit;
  logic                            accept;
  logic                            unused_vlan_hi;

  assign idx            = vlan_id_in[KEY_OFF_ADDR_WIDTH-1:0];
  assign unused_vlan_hi = ^vlan_id_in[C_VLANID_WIDTH-1:KEY_OFF_ADDR_WIDTH];
  assign wr_hit         = cfg_wr_en && (cfg_wr_stage == StageSel);
  assign accept         = (state_q == StIdle) && phv_valid_in;
  assign phv_out        = phv_q;

  // Read-first RAM: a same-cycle write to the read index returns the old word.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[cfg_wr_addr] <= {cfg_wr_offset, cfg_wr_mask};
    end
    if (accept) begin
      rd_data_q <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_vld_q <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      if (wr_hit) begin
        entry_vld_q[cfg_wr_addr] <= 1'b1;
      end
      // Valid bit is snapshotted with the data so later writes cannot touch the beat.
      if (accept) begin
        rd_hit_q <= entry_vld_q[idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_out = 1'b1;
        if (phv_valid_in) begin
          state_d = StLookup;
        end
      end
      StLookup: state_d = StEmit;
      StEmit: begin
        if (ready_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      phv_q            <= '0;
      phv_valid_out    <= 1'b0;
      key_offset_valid <= 1'b0;
      key_offset_out   <= '0;
      key_mask_out     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        phv_q <= phv_in;
      end
      if (state_q == StLookup) begin
        phv_valid_out    <= 1'b1;
        key_offset_valid <= rd_hit_q;
        key_offset_out   <= rd_hit_q ? rd_data_q[EntryW-1 -: KEY_OFF] : '0;
        key_mask_out     <= rd_hit_q ? rd_data_q[KEY_LEN-1:0] : '1;
      end else if ((state_q == StEmit) && ready_in) begin
        phv_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_offset_lookup.sv
// Randomized directed bench for key_offset_lookup against a table-level reference model.
module tb_key_offset_lookup;

  logic           clk = 1'b0;
  logic           rst;
  logic [1023:0]  phv_in;
  logic           phv_valid_in;
  logic [11:0]    vlan_id_in;
  logic           ready_out;
  logic           cfg_wr_en;
  logic [7:0]     cfg_wr_stage;
  logic [3:0]     cfg_wr_addr;
  logic [37:0]    cfg_wr_offset;
  logic [192:0]   cfg_wr_mask;
  logic [1023:0]  phv_out;
  logic           phv_valid_out;
  logic           key_offset_valid;
  logic [37:0]    key_offset_out;
  logic [192:0]   key_mask_out;
  logic           ready_in;

  key_offset_lookup dut (
    .clk              (clk),
    .rst              (rst),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .vlan_id_in       (vlan_id_in),
    .ready_out        (ready_out),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_stage     (cfg_wr_stage),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_offset    (cfg_wr_offset),
    .cfg_wr_mask      (cfg_wr_mask),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .key_offset_valid (key_offset_valid),
    .key_offset_out   (key_offset_out),
    .key_mask_out     (key_mask_out),
    .ready_in         (ready_in)
  );

  always #5 clk = ~clk;

  // Reference table: what stage 0 has been told, entry by entry.
  logic [37:0]  m_off  [16];
  logic [192:0] m_mask [16];
  bit           m_vld  [16];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [37:0] rand_off();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[37:0];
  endfunction

  function automatic logic [192:0] rand_mask();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[192:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  task automatic drive_wr(input logic [7:0] stage, input logic [3:0] addr,
                          input logic [37:0] off, input logic [192:0] mask);
    cfg_wr_en     = 1'b1;
    cfg_wr_stage  = stage;
    cfg_wr_addr   = addr;
    cfg_wr_offset = off;
    cfg_wr_mask   = mask;
    if (stage == 8'd0) begin
      m_off[addr]  = off;
      m_mask[addr] = mask;
      m_vld[addr]  = 1'b1;
    end
  endtask

  task automatic cfg_write(input logic [7:0] stage, input logic [3:0] addr,
                           input logic [37:0] off, input logic [192:0] mask);
    drive_wr(stage, addr, off, mask);
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [1023:0] e_phv, input bit e_hit,
                            input logic [37:0] e_off, input logic [192:0] e_mask);
    chk({tag, "_valid"}, phv_valid_out, 1'b1);
    chk({tag, "_ready"}, ready_out, 1'b0);
    chk({tag, "_hit"}, key_offset_valid, e_hit);
    chk({tag, "_off"}, key_offset_out, e_off);
    chk({tag, "_mask"}, key_mask_out, e_mask);
    for (int k = 0; k < 4; k++) chk({tag, "_phv"}, phv_out[k*256 +: 256], e_phv[k*256 +: 256]);
  endtask

  // Starts just after a negedge with the DUT idle; ends just after a negedge, idle again.
  task automatic lookup(input string tag, input logic [11:0] vlan, input int stall,
                        input bit coll_wr, input bit mid_wr);
    logic [1023:0] e_phv;
    logic [37:0]   e_off;
    logic [192:0]  e_mask;
    logic [3:0]    idx;
    bit            e_hit;
    idx    = vlan[3:0];
    e_phv  = rand_phv();
    e_hit  = m_vld[idx];
    e_off  = e_hit ? m_off[idx] : 38'd0;
    e_mask = e_hit ? m_mask[idx] : {193{1'b1}};
    chk({tag, "_idle_ready"}, ready_out, 1'b1);
    phv_in       = e_phv;
    vlan_id_in   = vlan;
    phv_valid_in = 1'b1;
    ready_in     = (stall == 0);
    if (coll_wr) drive_wr(8'd0, idx, rand_off(), rand_mask());
    @(negedge clk);
    cfg_wr_en  = 1'b0;
    // Keep offering junk while busy; it must be ignored.
    phv_in     = rand_phv();
    vlan_id_in = 12'($urandom);
    chk({tag, "_lookup_valid"}, phv_valid_out, 1'b0);
    chk({tag, "_lookup_ready"}, ready_out, 1'b0);
    @(negedge clk);
    check_beat(tag, e_phv, e_hit, e_off, e_mask);
    for (int s = 0; s < stall; s++) begin
      if (mid_wr) drive_wr(8'd0, idx, rand_off(), rand_mask());
      @(negedge clk);
      cfg_wr_en = 1'b0;
      check_beat({tag, "_stall"}, e_phv, e_hit, e_off, e_mask);
    end
    ready_in = 1'b1;
    @(negedge clk);
    phv_valid_in = 1'b0;
    chk({tag, "_done_valid"}, phv_valid_out, 1'b0);
    chk({tag, "_done_ready"}, ready_out, 1'b1);
  endtask

  initial begin
    rst = 1'b1; phv_in = '0; phv_valid_in = 1'b0; vlan_id_in = '0; ready_in = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_stage = '0; cfg_wr_addr = '0; cfg_wr_offset = '0; cfg_wr_mask = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_phv_valid", phv_valid_out, 1'b0);
    chk("rst_hit", key_offset_valid, 1'b0);
    chk("rst_off", key_offset_out, 38'd0);
    chk("rst_mask", key_mask_out, 193'd0);
    chk("rst_phv", phv_out[255:0], 256'd0);
    chk("rst_ready", ready_out, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    lookup("miss_v5", 12'd5, 0, 1'b0, 1'b0);
    cfg_write(8'd1, 4'd3, 38'h15_5555_5555, 193'd0);
    lookup("other_stage", 12'd3, 0, 1'b0, 1'b0);
    cfg_write(8'd0, 4'd3, 38'h2A_AAAA_AAAA, 193'd0);
    lookup("hit_v013", 12'h013, 0, 1'b0, 1'b0);
    chk("hit_v013_model", {255'd0, m_vld[3]}, 256'd1);
    lookup("stall5", 12'h013, 5, 1'b0, 1'b1);
    cfg_write(8'd0, 4'd7, rand_off(), rand_mask());
    lookup("coll_old", 12'd7, 0, 1'b1, 1'b0);
    lookup("coll_new", 12'h107, 0, 1'b0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(8'($urandom_range(0, 1)), 4'($urandom), rand_off(), rand_mask());
      lookup("rand", 12'($urandom), int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset while a beat is waiting in EMIT.
    phv_in = rand_phv(); vlan_id_in = 12'd3; phv_valid_in = 1'b1; ready_in = 1'b0;
    @(negedge clk);
    phv_valid_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", phv_valid_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_in = 1'b1;
    model_clear();
    chk("mid_rst_valid", phv_valid_out, 1'b0);
    chk("mid_rst_ready", ready_out, 1'b1);
    chk("mid_rst_phv", phv_out[1023:768], 256'd0);
    lookup("post_rst_v3", 12'd3, 0, 1'b0, 1'b0);
    lookup("post_rst_v7", 12'd7, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
